regfile_mp: RTL and testbench

Parametrised multi-read-port register file, successor to the fixed 8-bit dual-read regfile. It has one write port and NUM_RD registered read ports, and a hardware clear sequencer that zeroes every entry after reset or on request. It also has an out-of-range address flag and an optional write-to-read bypass. It sits in the same flow and goldenbrick-driven test environment as the existing regfile.

---
 rtl/regfile_mp.sv | 146 ++++++++++++++
 tb/tb_regfile_mp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware clear sequencer, out-of-range flag and
// optional write-first bypass (define REGFILE_BYPASS_EN to enable; default is read-first).

module regfile_mp_rd_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              zero,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] q,
  output logic              oob
);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);

  assign oob = ({1'b0, addr} >= DEPTH_L);

  always_ff @(posedge clk) begin
    if (reset || zero)  q <= '0;
    else if (load) begin
      if (oob)          q <= '0;
      else if (byp_hit) q <= byp_data;
      else              q <= rdata;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_enable,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        in,
  input  logic                     rd_enable,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] out,
  input  logic                     clear,
  output logic                     busy,
  output logic                     oob
);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]              mem [DEPTH];
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_a;
  logic [NUM_RD-1:0][DATA_W-1:0]  rdata, out_q;
  logic [NUM_RD-1:0]              byp_hit, rd_oob;
  logic                           acc, wr_acc, rd_acc, wr_in_rng;

  assign rd_addr_a = rd_addr;
  assign out       = out_q;
  assign busy      = (state_q == CLEAR);

  // clear in READY wins over any access issued in the same cycle
  assign acc       = (state_q == READY) && !clear;
  assign wr_acc    = acc && wr_enable;
  assign rd_acc    = acc && rd_enable;
  assign wr_in_rng = ({1'b0, wr_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR)        mem[clr_addr_q] <= '0;
      else if (wr_acc && wr_in_rng) mem[wr_addr]   <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) oob <= 1'b0;
    else       oob <= (wr_acc && !wr_in_rng) || (rd_acc && (|rd_oob));
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rdata[i] = mem[rd_addr_a[i]];
`ifdef REGFILE_BYPASS_EN
    assign byp_hit[i] = wr_acc && wr_in_rng && (wr_addr == rd_addr_a[i]);
`else
    assign byp_hit[i] = 1'b0;
`endif

    regfile_mp_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .load     (rd_acc),
      .zero     (!acc),
      .addr     (rd_addr_a[i]),
      .rdata    (rdata[i]),
      .byp_hit  (byp_hit[i]),
      .byp_data (in),
      .q        (out_q[i]),
      .oob      (rd_oob[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DEPTH=12, ADDR_W=4, NUM_RD=2); expectations follow
// REGFILE_BYPASS_EN the same way as the design build.

module tb_regfile_mp;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DEP = 12;
  localparam int NR  = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [NR*DW-1:0] out;
    logic             oob;
    string            tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_enable = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     in = '0;
  logic              rd_enable = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  out;
  logic              clear = 1'b0;
  logic              busy;
  logic              oob;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_RD(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .in        (in),
    .rd_enable (rd_enable),
    .rd_addr   (rd_addr),
    .out       (out),
    .clear     (clear),
    .busy      (busy),
    .oob       (oob)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic clr);
    wr_enable = we; wr_addr = wa; in = wd;
    rd_enable = re; rd_addr = {ra1, ra0}; clear = clr;
  endtask

  task automatic push(input string tag, input logic [DW-1:0] o1, input logic [DW-1:0] o0,
                      input logic ob);
    exp_t x;
    x.out = {o1, o0}; x.oob = ob; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    int  cnt;
    bit  zero_ok;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      n_chk += 3;
      if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else n_pass++;
      if (out !== '0) $display("FAIL reset_out got %h want 0", out); else n_pass++;
      if (oob !== 1'b0) $display("FAIL reset_oob got %b want 0", oob); else n_pass++;
    end
    reset = 1'b0;
    cnt = 0; zero_ok = 1'b1;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
      if (out !== '0) zero_ok = 1'b0;
    end
    n_chk += 2;
    if (cnt != DEP) $display("FAIL reset_busy_len got %0d want %0d", cnt, DEP); else n_pass++;
    if (!zero_ok) $display("FAIL reset_out_zero got nonzero want 0"); else n_pass++;
    for (int a = 0; a < DEP; a += 2) begin
      push("reset_readback", 0, 0, 0);
      drive(0, 0, 0, 1, AW'(a), AW'(a + 1), 0);
      step();
      e = sb.pop_front(); n_chk += 2;
      if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
      if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    end
  endtask

  task automatic test_basic;
    push("basic_wr3", 0, 0, 0);          drive(1, 3, 8'hA5, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("basic_wr7", 0, 0, 0);          drive(1, 7, 8'h5A, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("basic_rd", 8'h5A, 8'hA5, 0);   drive(0, 0, 0, 1, 3, 7, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("basic_hold", 8'h5A, 8'hA5, 0); drive(0, 0, 0, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("basic_wr_last", 8'h5A, 8'hA5, 0); drive(1, 11, 8'hC3, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("basic_same_addr", 8'hC3, 8'hC3, 0); drive(0, 0, 0, 1, 11, 11, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
  endtask

  task automatic test_collision;
    push("coll_prewr", 8'hC3, 8'hC3, 0); drive(1, 5, 8'h11, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("coll_same_cycle", 8'hA5, BYP ? 8'h22 : 8'h11, 0); drive(1, 5, 8'h22, 1, 5, 3, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("coll_after", 8'h22, 8'h22, 0); drive(0, 0, 0, 1, 5, 5, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
  endtask

  task automatic test_oob;
    push("oob_wr13", 8'h22, 8'h22, 1); drive(1, 13, 8'hFF, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("oob_rd14", 8'h00, 8'h22, 1); drive(0, 0, 0, 1, 5, 14, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    // addresses 1 and 11 would be the alias targets if the 13 write leaked in
    push("oob_inrange", 8'hC3, 8'h00, 0); drive(0, 0, 0, 1, 1, 11, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("oob_wr12", 8'h00, 8'h00, 1); drive(1, 12, 8'hEE, 1, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("oob_idle", 8'h00, 8'h00, 0); drive(0, 0, 0, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
  endtask

  task automatic test_clear;
    int cnt;
    bit quiet_ok;
    push("clr_wr2", 0, 0, 0); drive(1, 2, 8'h77, 0, 0, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("clr_rd2", 8'h77, 8'h77, 0); drive(0, 0, 0, 1, 2, 2, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    drive(1, 6, 8'h44, 1, 2, 2, 1);
    step();
    n_chk += 2;
    if (busy !== 1'b1) $display("FAIL clr_busy_rise got %b want 1", busy); else n_pass++;
    if (out !== '0) $display("FAIL clr_out_zero got %h want 0", out); else n_pass++;
    cnt = 0; quiet_ok = 1'b1;
    while (busy === 1'b1 && cnt < 100) begin
      drive(1, 4, 8'h33, 1, 13, 4, cnt == 3);
      step();
      cnt++;
      if (out !== '0 || oob !== 1'b0) quiet_ok = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_chk += 2;
    if (cnt != DEP) $display("FAIL clr_busy_len got %0d want %0d", cnt, DEP); else n_pass++;
    if (!quiet_ok) $display("FAIL clr_quiet got activity want out=0 oob=0"); else n_pass++;
    push("clr_rd24", 8'h00, 8'h00, 0); drive(0, 0, 0, 1, 2, 4, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
    push("clr_rd6", 8'h00, 8'h00, 0); drive(0, 0, 0, 1, 6, 0, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    drive(1, 9, 8'h99, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (9) step();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL rmc_busy_mid got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    n_chk++;
    if (cnt != DEP) $display("FAIL rmc_busy_len got %0d want %0d", cnt, DEP); else n_pass++;
    push("rmc_rd9", 8'h00, 8'h00, 0); drive(0, 0, 0, 1, 9, 11, 0);
    step(); e = sb.pop_front(); n_chk += 2;
    if (out !== e.out) $display("FAIL %s out got %h want %h", e.tag, out, e.out); else n_pass++;
    if (oob !== e.oob) $display("FAIL %s oob got %b want %b", e.tag, oob, e.oob); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ra0;
    logic [DW-1:0] x0, x1;
    for (int k = 0; k < DEP; k++) begin
      ra0 = AW'((k + DEP - 1) % DEP);
      x0  = (k == 0) ? 8'h00 : DW'(8'h40 + k - 1);
      x1  = BYP ? DW'(8'h40 + k) : 8'h00;
      push("b2b_stream", x1, x0, 0);
      drive(1, AW'(k), DW'(8'h40 + k), 1, ra0, AW'(k), 0);
      step(); e = sb.pop_front(); n_chk += 2;
      if (out !== e.out) $display("FAIL %s k=%0d out got %h want %h", e.tag, k, out, e.out); else n_pass++;
      if (oob !== e.oob) $display("FAIL %s k=%0d oob got %b want %b", e.tag, k, oob, e.oob); else n_pass++;
    end
    for (int k = 0; k < DEP; k++) begin
      push("b2b_read", DW'(8'h40 + DEP - 1 - k), DW'(8'h40 + k), 0);
      drive(0, 0, 0, 1, AW'(k), AW'(DEP - 1 - k), 0);
      step(); e = sb.pop_front(); n_chk += 2;
      if (out !== e.out) $display("FAIL %s k=%0d out got %h want %h", e.tag, k, out, e.out); else n_pass++;
      if (oob !== e.oob) $display("FAIL %s k=%0d oob got %b want %b", e.tag, k, oob, e.oob); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
